// File: rtl/conv_window_gen_pkg.sv
// Shared definitions for the 3x3 window generator and its downstream 9-cell PE.
package conv_window_gen_pkg;

    localparam int unsigned CELL_BIT_DEF  = 8;
    localparam int unsigned N_CELL_DEF    = 9;
    localparam int unsigned DIM_BITS_DEF  = 7;
    localparam int unsigned MAX_WIDTH_DEF = 64;
    localparam int unsigned WIN_DIM       = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Cell k occupies win[cell_msb(k) -: cell_bit]; cell 0 is the top-left (oldest) pixel.
    function automatic int unsigned cell_msb(input int unsigned k, input int unsigned cell_bit);
        return cell_bit * (N_CELL_DEF - k) - 1;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of pixel storage: asynchronous read, synchronous write.
module conv_line_buffer #(
    parameter int unsigned MAX_WIDTH = conv_window_gen_pkg::MAX_WIDTH_DEF,
    parameter int unsigned CELL_BIT  = conv_window_gen_pkg::CELL_BIT_DEF,
    parameter int unsigned ADDR_BITS = $clog2(MAX_WIDTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [CELL_BIT-1:0]  wdata,
    output logic [CELL_BIT-1:0]  rdata
);

    logic [CELL_BIT-1:0] mem [MAX_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream to 3x3 convolution windows (no padding, stride 1).
// Optional win_last output enabled by defining CONV_WINDOW_LAST_EN.
module conv_window_gen
    import conv_window_gen_pkg::*;
#(
    parameter int unsigned CELL_BIT  = CELL_BIT_DEF,
    parameter int unsigned N_CELL    = N_CELL_DEF,
    parameter int unsigned MAX_WIDTH = MAX_WIDTH_DEF,
    parameter int unsigned DIM_BITS  = DIM_BITS_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [DIM_BITS-1:0]        cfg_width,
    input  logic [DIM_BITS-1:0]        cfg_height,
    input  logic [CELL_BIT-1:0]        pix,
    input  logic                       pix_valid,
    output logic                       busy,
    output logic [CELL_BIT*N_CELL-1:0] win,
    output logic                       win_valid,
    output logic                       frame_done,
    output logic                       cfg_err
`ifdef CONV_WINDOW_LAST_EN
    ,
    output logic                       win_last
`endif
);

    localparam int unsigned ADDR_BITS = $clog2(MAX_WIDTH);

    state_t              state;
    logic [DIM_BITS-1:0] row;
    logic [DIM_BITS-1:0] col;
    logic [DIM_BITS-1:0] w_cfg;
    logic [DIM_BITS-1:0] h_cfg;
    logic [CELL_BIT-1:0] cells [N_CELL];
    logic [CELL_BIT-1:0] nxt_cells [N_CELL];
    logic [CELL_BIT-1:0] lb0_rd;
    logic [CELL_BIT-1:0] lb1_rd;
    logic                cfg_ok_c;
    logic                accept_c;
    logic                at_last_c;
    logic                in_window_c;

    always_comb begin
        cfg_ok_c    = (cfg_width >= DIM_BITS'(3)) && (cfg_width <= DIM_BITS'(MAX_WIDTH))
                      && (cfg_height >= DIM_BITS'(3));
        accept_c    = (state == RUN) && pix_valid && !start;
        at_last_c   = (row == h_cfg - DIM_BITS'(1)) && (col == w_cfg - DIM_BITS'(1));
        in_window_c = (row >= DIM_BITS'(2)) && (col >= DIM_BITS'(2));
    end

    // LB0 holds row r-2, LB1 holds row r-1 at each column.
    conv_line_buffer #(
        .MAX_WIDTH (MAX_WIDTH),
        .CELL_BIT  (CELL_BIT),
        .ADDR_BITS (ADDR_BITS)
    ) u_lb0 (
        .clk   (clk),
        .we    (accept_c),
        .addr  (col[ADDR_BITS-1:0]),
        .wdata (lb1_rd),
        .rdata (lb0_rd)
    );

    conv_line_buffer #(
        .MAX_WIDTH (MAX_WIDTH),
        .CELL_BIT  (CELL_BIT),
        .ADDR_BITS (ADDR_BITS)
    ) u_lb1 (
        .clk   (clk),
        .we    (accept_c),
        .addr  (col[ADDR_BITS-1:0]),
        .wdata (pix),
        .rdata (lb1_rd)
    );

    // Shift window left one column; new right column is {row r-2, row r-1, row r}.
    always_comb begin
        for (int unsigned k = 0; k < N_CELL; k++) begin
            nxt_cells[k] = cells[k];
        end
        for (int unsigned r = 0; r < WIN_DIM; r++) begin
            nxt_cells[WIN_DIM*r]     = cells[WIN_DIM*r + 1];
            nxt_cells[WIN_DIM*r + 1] = cells[WIN_DIM*r + 2];
        end
        nxt_cells[2] = lb0_rd;
        nxt_cells[5] = lb1_rd;
        nxt_cells[8] = pix;
    end

    always_comb begin
        win = '0;
        for (int unsigned k = 0; k < N_CELL; k++) begin
            win[cell_msb(k, CELL_BIT) -: CELL_BIT] = cells[k];
        end
    end

    // Control FSM, counters and window registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
            row        <= '0;
            col        <= '0;
            w_cfg      <= '0;
            h_cfg      <= '0;
            for (int unsigned k = 0; k < N_CELL; k++) begin
                cells[k] <= '0;
            end
`ifdef CONV_WINDOW_LAST_EN
            win_last   <= 1'b0;
`endif
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
`ifdef CONV_WINDOW_LAST_EN
            win_last   <= 1'b0;
`endif
            if (start) begin
                if (cfg_ok_c) begin
                    w_cfg <= cfg_width;
                    h_cfg <= cfg_height;
                    row   <= '0;
                    col   <= '0;
                    state <= RUN;
                    busy  <= 1'b1;
                end else begin
                    cfg_err <= 1'b1;
                    state   <= IDLE;
                    busy    <= 1'b0;
                end
            end else if (accept_c) begin
                for (int unsigned k = 0; k < N_CELL; k++) begin
                    cells[k] <= nxt_cells[k];
                end
                win_valid <= in_window_c;
                if (col == w_cfg - DIM_BITS'(1)) begin
                    col <= '0;
                    row <= row + DIM_BITS'(1);
                end else begin
                    col <= col + DIM_BITS'(1);
                end
                if (at_last_c) begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
`ifdef CONV_WINDOW_LAST_EN
                    win_last   <= 1'b1;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed self-checking bench for conv_window_gen (win_last checked when CONV_WINDOW_LAST_EN is defined).
module tb_conv_window_gen;
    import conv_window_gen_pkg::*;

    localparam int MAXW = int'(MAX_WIDTH_DEF);

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  cfg_width = '0;
    logic [6:0]  cfg_height = '0;
    logic [7:0]  pix = '0;
    logic        pix_valid = 1'b0;
    logic        busy;
    logic [71:0] win;
    logic        win_valid;
    logic        frame_done;
    logic        cfg_err;
`ifdef CONV_WINDOW_LAST_EN
    logic        win_last;
`endif

    int n_checks = 0;
    int n_err = 0;

    logic [71:0] win_q [$];
    int          fd_cnt = 0;
    int          err_cnt = 0;
    int          gap_viol = 0;
    int          last_cnt = 0;
    logic        pv_last = 1'b0;

    logic [71:0] exp4 [4] = '{72'h01_02_03_05_06_07_09_0a_0b,
                              72'h02_03_04_06_07_08_0a_0b_0c,
                              72'h05_06_07_09_0a_0b_0d_0e_0f,
                              72'h06_07_08_0a_0b_0c_0e_0f_10};
    int bad_w [3] = '{2, 4, MAXW + 1};
    int bad_h [3] = '{4, 2, 4};

    conv_window_gen dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .pix        (pix),
        .pix_valid  (pix_valid),
        .busy       (busy),
        .win        (win),
        .win_valid  (win_valid),
        .frame_done (frame_done),
        .cfg_err    (cfg_err)
`ifdef CONV_WINDOW_LAST_EN
        ,
        .win_last   (win_last)
`endif
    );

    always #5 clk = ~clk;

    // Collect windows and pulse counts away from the active edge.
    always @(negedge clk) begin
        if (win_valid) win_q.push_back(win);
        if (frame_done) fd_cnt++;
        if (cfg_err) err_cnt++;
        if (win_valid && !pv_last) gap_viol++;
`ifdef CONV_WINDOW_LAST_EN
        if (win_last) last_cnt++;
`endif
        pv_last = pix_valid;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] exp_win(input logic [7:0] base, input int w, input int r, input int c);
        logic [71:0] v;
        v = '0;
        for (int rr = 0; rr < 3; rr++)
            for (int cc = 0; cc < 3; cc++)
                v[71 - 8*(3*rr + cc) -: 8] = base + 8'((r - 2 + rr) * w + (c - 2 + cc));
        return v;
    endfunction

    task automatic start_frame(input int w, input int h, input logic pv);
        start = 1'b1;
        cfg_width = 7'(w);
        cfg_height = 7'(h);
        pix_valid = pv;
        pix = 8'hFF;
        cyc();
        start = 1'b0;
        pix_valid = 1'b0;
    endtask

    task automatic send_pix(input logic [7:0] v, input bit gaps);
        if (gaps) begin
            int n = int'($urandom_range(0, 2));
            repeat (n) begin
                pix = 8'($urandom);
                cyc();
            end
        end
        pix_valid = 1'b1;
        pix = v;
        cyc();
        pix_valid = 1'b0;
    endtask

    task automatic send_pixels(input logic [7:0] base, input int n, input bit gaps);
        for (int i = 0; i < n; i++) send_pix(base + 8'(i), gaps);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] base, input int w, input int h);
        int nwin = (w - 2) * (h - 2);
        check_eq({tag, "_count"}, 72'(win_q.size()), 72'(nwin));
        for (int i = 0; i < nwin && i < win_q.size(); i++)
            check_eq($sformatf("%s_win%0d", tag, i), win_q[i],
                     exp_win(base, w, 2 + i / (w - 2), 2 + i % (w - 2)));
    endtask

    task automatic check_4x4(input string tag);
        check_eq({tag, "_count"}, 72'(win_q.size()), 72'd4);
        for (int i = 0; i < 4 && i < win_q.size(); i++)
            check_eq($sformatf("%s_win%0d", tag, i), win_q[i], exp4[i]);
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_busy"}, 72'(busy), 72'd0);
        check_eq({tag, "_win_valid"}, 72'(win_valid), 72'd0);
        check_eq({tag, "_frame_done"}, 72'(frame_done), 72'd0);
        check_eq({tag, "_cfg_err"}, 72'(cfg_err), 72'd0);
        check_eq({tag, "_win"}, win, 72'd0);
    endtask

    initial begin
        repeat (2) cyc();
        check_idle_zero("reset");
        reset = 1'b1;
        cyc();

        // 4x4 frame, consecutive pixels
        win_q.delete(); fd_cnt = 0;
        start_frame(4, 4, 1'b0);
        check_eq("t1_busy", 72'(busy), 72'd1);
        send_pixels(8'd1, 16, 1'b0);
        check_eq("t1_done_pulse", 72'(frame_done), 72'd1);
        check_eq("t1_last_valid", 72'(win_valid), 72'd1);
`ifdef CONV_WINDOW_LAST_EN
        check_eq("t1_win_last", 72'(win_last), 72'd1);
`endif
        cyc();
        check_eq("t1_done_clear", 72'(frame_done), 72'd0);
        check_eq("t1_busy_clear", 72'(busy), 72'd0);
        repeat (2) cyc();
        check_4x4("t1");
        check_eq("t1_fd_cnt", 72'(fd_cnt), 72'd1);

        // Same frame with random pix_valid gaps
        win_q.delete(); fd_cnt = 0; gap_viol = 0;
        start_frame(4, 4, 1'b0);
        send_pixels(8'd1, 16, 1'b1);
        repeat (3) cyc();
        check_4x4("t2");
        check_eq("t2_gap_viol", 72'(gap_viol), 72'd0);
        check_eq("t2_fd_cnt", 72'(fd_cnt), 72'd1);

        // Back-to-back frames 5x3 then 3x3
        win_q.delete();
        start_frame(5, 3, 1'b0);
        send_pixels(8'h40, 15, 1'b0);
        repeat (2) cyc();
        check_frame("t3a", 8'h40, 5, 3);
        win_q.delete();
        start_frame(3, 3, 1'b0);
        send_pixels(8'h90, 9, 1'b0);
        repeat (2) cyc();
        check_frame("t3b", 8'h90, 3, 3);

        // Rejected configurations
        for (int i = 0; i < 3; i++) begin
            win_q.delete(); err_cnt = 0;
            start_frame(bad_w[i], bad_h[i], 1'b0);
            check_eq($sformatf("t4_%0d_cfg_err", i), 72'(cfg_err), 72'd1);
            check_eq($sformatf("t4_%0d_busy", i), 72'(busy), 72'd0);
            cyc();
            check_eq($sformatf("t4_%0d_err_pulse", i), 72'(cfg_err), 72'd0);
            send_pixels(8'h10, 12, 1'b0);
            repeat (2) cyc();
            check_eq($sformatf("t4_%0d_no_win", i), 72'(win_q.size()), 72'd0);
            check_eq($sformatf("t4_%0d_busy_after", i), 72'(busy), 72'd0);
            check_eq($sformatf("t4_%0d_err_cnt", i), 72'(err_cnt), 72'd1);
        end

        // Restart mid-frame at row 2, with a same-cycle pixel that must be dropped
        fd_cnt = 0;
        start_frame(4, 4, 1'b0);
        send_pixels(8'h20, 11, 1'b0);
        start_frame(3, 4, 1'b1);
        check_eq("t5_no_done", 72'(fd_cnt), 72'd0);
        check_eq("t5_busy", 72'(busy), 72'd1);
        win_q.delete();
        send_pixels(8'hA0, 12, 1'b0);
        repeat (2) cyc();
        check_frame("t5", 8'hA0, 3, 4);
        check_eq("t5_fd_cnt", 72'(fd_cnt), 72'd1);

        // Reset mid-frame, then a clean frame
        start_frame(4, 4, 1'b0);
        send_pixels(8'd1, 11, 1'b0);
        check_eq("t6_pre_valid", 72'(win_valid), 72'd1);
        reset = 1'b0;
        cyc();
        check_idle_zero("t6_reset");
        reset = 1'b1;
        cyc();
        win_q.delete(); fd_cnt = 0;
        start_frame(4, 4, 1'b0);
        send_pixels(8'd1, 16, 1'b0);
        repeat (2) cyc();
        check_4x4("t6");
        check_eq("t6_fd_cnt", 72'(fd_cnt), 72'd1);

        // Widest row
        win_q.delete(); last_cnt = 0;
        start_frame(MAXW, 3, 1'b0);
        send_pixels(8'd0, 3 * MAXW, 1'b0);
        check_eq("t7_done_pulse", 72'(frame_done), 72'd1);
`ifdef CONV_WINDOW_LAST_EN
        check_eq("t7_win_last", 72'(win_last), 72'd1);
`endif
        repeat (2) cyc();
        check_frame("t7", 8'd0, MAXW, 3);
`ifdef CONV_WINDOW_LAST_EN
        check_eq("t7_last_cnt", 72'(last_cnt), 72'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Converts a raster pixel stream into 3x3 convolution windows, one per valid output position (no padding, stride 1).
- Sits directly upstream of the 9-cell processing element. The 72-bit window bus connects to the PE input operand, and win_valid drives the PE enable.
- Holds two row line buffers plus a 3x3 shift-register window. There is no backpressure.

Parameters:
- CELL_BIT, 8, bits per pixel.
- N_CELL, 9, window cells; fixed 3x3, not user-changeable.
- MAX_WIDTH, 64, largest supported row length, which sets the line-buffer depth.
- DIM_BITS, 7, width of the dimension inputs and counters; must hold MAX_WIDTH.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; latches the config and begins a frame
- cfg_width  in  DIM_BITS  columns per row; legal range 3..MAX_WIDTH
- cfg_height  in  DIM_BITS  rows per frame; legal values are >=3
- pix  in  CELL_BIT  pixel, signed 8-bit
- pix_valid  in  1  pixel qualifier
- busy  out  1  high while a frame is in progress
- win  out  CELL_BIT*N_CELL  window; cell k at bits [71-8k -: 8], k = 3*row + col, cell 0 = top-left (oldest row, oldest column)
- win_valid  out  1  win holds a valid window this cycle
- frame_done  out  1  one-cycle pulse after the last pixel of the frame is accepted
- cfg_err  out  1  one-cycle pulse when a start is rejected

Behaviour:
- Reset (reset==0 at a clk edge):
  - state goes to IDLE.
  - busy, win_valid, frame_done and cfg_err go to 0.
  - win and the row/column counters clear to 0.
  - Line-buffer contents are don't-care.
- FSM states: IDLE and RUN.
  - IDLE: pix_valid is ignored. On start:
    - Legal dimensions: latch W=cfg_width and H=cfg_height, clear row/col, go to RUN, busy=1 from the next cycle.
    - Illegal dimensions (cfg_width<3, cfg_width>MAX_WIDTH, or cfg_height<3): stay in IDLE, cfg_err=1 for one cycle.
  - RUN: each cycle with pix_valid=1 accepts one pixel at (row, col).
  - RUN, start asserted: the frame is abandoned. The legality check and latch are the same as in IDLE. A rejected start returns to IDLE. start takes priority over a same-cycle pix_valid, and that pixel is dropped.
- Per accepted pixel at column c:
  - Read LB0[c] (row r-2) and LB1[c] (row r-1).
  - Write LB0[c] <= LB1[c] and LB1[c] <= pix.
  - Shift the window left one column. The new right column is {LB0[c], LB1[c], pix}, top to bottom.
- Counters:
  - col increments and wraps to 0 at W-1; the wrap increments row.
  - On the pixel at (H-1, W-1): go to IDLE, busy=0 and frame_done=1 on the next cycle.
- win_valid timing:
  - Registered; asserted the cycle after accepting a pixel with r>=2 and c>=2.
  - At most one window per accepted pixel.
  - The frame produces exactly (W-2)*(H-2) windows.
- Gaps: pix_valid=0 holds win and all state unchanged, and win_valid=0 that cycle.
- Stale data: window columns left over from the previous row, and line-buffer data from a prior frame, never appear in a valid window. Validity is gated by r>=2 and c>=2 only, so no clearing is needed.
- win holds its last value when win_valid=0.
- Arithmetic is pure data movement; pixel values pass through bit-exact.

Optional Feature:
- Macro: CONV_WINDOW_LAST_EN.
- When defined: adds output port win_last (1 bit, reset 0). It is high together with win_valid on the final window of a frame, i.e. the window ending at (H-1, W-1), in the same cycle frame_done pulses.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - CELL_BIT, N_CELL and DIM_BITS defaults.
  - The cell-index-to-bit-slice convention (cell k at bits [71-8k -: 8]), shared with the PE.
  - FSM state encoding: IDLE=1'b0, RUN=1'b1.
- Sub-module: conv_line_buffer, a single-row MAX_WIDTH x CELL_BIT storage with asynchronous read and synchronous write enable. It is instantiated twice (LB0, LB1).

Test Plan:
- 4x4 frame, pixels 1..16 on consecutive cycles:
  - Exactly 4 windows.
  - First window cells {1,2,3,5,6,7,9,10,11}, with win[71:64]=1 and win[7:0]=11.
  - Last window {6,7,8,10,11,12,14,15,16}.
  - frame_done one cycle after pixel 16 is accepted.
- Same 4x4 frame with random pix_valid gaps: identical window sequence, and win_valid never high in a cycle after pix_valid=0.
- Two back-to-back frames (5x3, then 3x3) with distinct data:
  - 3 windows, then 1 window.
  - No prior-frame data appears in any window.
- cfg_width=2, or cfg_height=2, or cfg_width=MAX_WIDTH+1: cfg_err pulses, busy stays 0, and subsequent pix_valid produces no windows.
- Control interruptions:
  - start mid-frame at row 2: the old frame is abandoned with no frame_done, and the new frame's window count is exact.
  - reset=0 mid-frame: all outputs are 0 on the next cycle, and the following frame is correct.
- MAX_WIDTH x 3 frame: MAX_WIDTH-2 windows, each with the expected column alignment. With CONV_WINDOW_LAST_EN defined, win_last is high only on the final window.
